fetch_pc_queue: RTL and testbench

Parametrised instruction-fetch PC unit: successor to the single-register IF stage. Generates sequential PCs, accepts branch/jump redirects, stalls on an enable input, and buffers issued PCs in a DEPTH-entry queue exposed to decode through a valid/ready handshake. Sits between the branch-resolution logic and the IF/ID boundary; the instruction memory address is taken from `pc`.

---
 rtl/fetch_pc_queue_pkg.sv | 11 +
 rtl/fetch_pc_queue_if.sv | 27 ++
 rtl/fetch_pc_queue_fifo.sv | 74 +++++++
 rtl/fetch_pc_queue.sv | 64 ++++++
 tb/tb_fetch_pc_queue.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_queue_pkg.sv
// Shared fetch-path constants and the PC type used by the fetch PC queue.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int FETCH_STEP = 4;

  typedef logic [FETCH_XLEN-1:0] pc_t;

  localparam pc_t FETCH_RESET_PC = '0;

endpackage

// File: rtl/fetch_pc_queue_if.sv
// Decode-side handshake of the fetch PC queue: head PC, its successor, valid/ready.
interface fetch_pc_queue_if
  import fetch_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN
);

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_next;

  modport master (
    output out_valid,
    output out_pc,
    output out_pc_next,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_pc,
    input  out_pc_next,
    output out_ready
  );

endinterface

// File: rtl/fetch_pc_queue_fifo.sv
// Count-based synchronous FIFO holding issued PCs; flush clears occupancy in one cycle.
module pc_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointers wrap by compare so that non-power-of-two depths stay dense.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_pc_queue.sv
// Fetch PC generator: sequential/redirected PC register feeding a queue drained by decode.
module fetch_pc_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter int              DEPTH    = 2,
  parameter int              STEP     = FETCH_STEP,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            target_i,
  output logic [XLEN-1:0]            pc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  fetch_pc_queue_if.master           out_if
);

  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(STEP - 1));

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] head_pc;
  logic            fifo_full, fifo_empty;
  logic            pop, enq;

  assign pop = out_if.out_valid && out_if.out_ready;
  // A pop frees a slot in the same edge, so a full queue can still accept.
  assign enq = en_i && !redirect_i && (!fifo_full || pop);

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) pc_d = target_i & ALIGN_MASK;
    else if (enq)   pc_d = pc_q + STEP_V;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  pc_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_i),
    .push_i  (enq),
    .pop_i   (pop && !redirect_i),
    .data_i  (pc_q),
    .data_o  (head_pc),
    .count_o (count_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pc_o               = pc_q;
  assign out_if.out_valid    = !fifo_empty;
  assign out_if.out_pc       = head_pc;
  assign out_if.out_pc_next  = head_pc + STEP_V;

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Scoreboarded bench for fetch_pc_queue: three parameter sets, directed vectors.
module tb_fetch_pc_queue;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic        rst_a = 1'b1, en_a = 1'b0, redir_a = 1'b0;
  logic [31:0] tgt_a = '0, pc_a;
  logic [1:0]  cnt_a;
  logic        rst_b = 1'b1, en_b = 1'b0, redir_b = 1'b0;
  logic [31:0] tgt_b = '0, pc_b;
  logic [1:0]  cnt_b;
  logic        rst_c = 1'b1, en_c = 1'b0, redir_c = 1'b0;
  logic [31:0] tgt_c = '0, pc_c;
  logic [1:0]  cnt_c;

  fetch_pc_queue_if #(.XLEN(32)) a_if ();
  fetch_pc_queue_if #(.XLEN(32)) b_if ();
  fetch_pc_queue_if #(.XLEN(32)) c_if ();

  fetch_pc_queue #(.XLEN(32), .DEPTH(2), .STEP(4), .RESET_PC(32'h0)) dut_a (
    .clk(clk), .rst(rst_a), .en_i(en_a), .redirect_i(redir_a), .target_i(tgt_a),
    .pc_o(pc_a), .count_o(cnt_a), .out_if(a_if));
  fetch_pc_queue #(.XLEN(32), .DEPTH(2), .STEP(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst(rst_b), .en_i(en_b), .redirect_i(redir_b), .target_i(tgt_b),
    .pc_o(pc_b), .count_o(cnt_b), .out_if(b_if));
  fetch_pc_queue #(.XLEN(32), .DEPTH(3), .STEP(4), .RESET_PC(32'h0)) dut_c (
    .clk(clk), .rst(rst_c), .en_i(en_c), .redirect_i(redir_c), .target_i(tgt_c),
    .pc_o(pc_c), .count_o(cnt_c), .out_if(c_if));

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] exp_c[$];
  int pops_c = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: an accepted head (valid && ready, no flush) must match the scoreboard.
  always @(negedge clk) begin
    if (!rst_a && !redir_a && a_if.out_valid && a_if.out_ready) begin
      if (exp_a.size() == 0) chk("a_unexpected_pop", a_if.out_pc, 32'hDEAD_BEEF ^ a_if.out_pc);
      else begin
        logic [31:0] e;
        e = exp_a.pop_front();
        chk("a_out_pc", a_if.out_pc, e);
        chk("a_out_pc_next", a_if.out_pc_next, e + 32'd4);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && !redir_b && b_if.out_valid && b_if.out_ready) begin
      if (exp_b.size() == 0) chk("b_unexpected_pop", b_if.out_pc, 32'hDEAD_BEEF ^ b_if.out_pc);
      else begin
        logic [31:0] e;
        e = exp_b.pop_front();
        chk("b_out_pc", b_if.out_pc, e);
        chk("b_out_pc_next", b_if.out_pc_next, e + 32'd4);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_c && !redir_c && c_if.out_valid && c_if.out_ready) begin
      if (exp_c.size() == 0) chk("c_unexpected_pop", c_if.out_pc, 32'hDEAD_BEEF ^ c_if.out_pc);
      else begin
        logic [31:0] e;
        e = exp_c.pop_front();
        chk("c_out_pc", c_if.out_pc, e);
        pops_c++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pat;
    pat = 16'hB6DB;
    a_if.out_ready = 1'b0;
    b_if.out_ready = 1'b0;
    c_if.out_ready = 1'b0;

    // ---- DUT A: DEPTH=2, RESET_PC=0 ----
    tick(); tick();
    @(negedge clk);
    chk("a_rst_pc", pc_a, 32'h0);
    chk("a_rst_count", 32'(cnt_a), 32'd0);
    chk("a_rst_valid", 32'(a_if.out_valid), 32'd0);
    tick();
    rst_a = 1'b0; en_a = 1'b1; a_if.out_ready = 1'b1;
    exp_a.push_back(32'h0); exp_a.push_back(32'h4); exp_a.push_back(32'h8);
    repeat (4) tick();
    a_if.out_ready = 1'b0;
    @(negedge clk);
    chk("a_seq_drained", 32'(exp_a.size()), 32'd0);
    chk("a_seq_count", 32'(cnt_a), 32'd1);

    // full-queue stall then pop+enqueue on the same edge
    tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("a_full_count", 32'(cnt_a), 32'd2);
    chk("a_full_pc", pc_a, 32'h8);
    chk("a_full_head", a_if.out_pc, 32'h0);
    tick();
    a_if.out_ready = 1'b1;
    exp_a.push_back(32'h0);
    tick();
    a_if.out_ready = 1'b0;
    @(negedge clk);
    chk("a_poppush_count", 32'(cnt_a), 32'd2);
    chk("a_poppush_pc", pc_a, 32'hC);
    chk("a_poppush_head", a_if.out_pc, 32'h4);

    // redirect with full queue, ready high: pop discarded
    tick();
    redir_a = 1'b1; tgt_a = 32'h100; a_if.out_ready = 1'b1;
    tick();
    redir_a = 1'b0;
    @(negedge clk);
    chk("a_redir_count", 32'(cnt_a), 32'd0);
    chk("a_redir_valid", 32'(a_if.out_valid), 32'd0);
    chk("a_redir_pc", pc_a, 32'h100);
    exp_a.push_back(32'h100);
    tick();
    tick();
    a_if.out_ready = 1'b0; en_a = 1'b0;
    @(negedge clk);
    chk("a_after_redir_count", 32'(cnt_a), 32'd1);
    chk("a_after_redir_pc", pc_a, 32'h108);
    chk("a_after_redir_drained", 32'(exp_a.size()), 32'd0);

    // misaligned redirect with en=0
    tick();
    redir_a = 1'b1; tgt_a = 32'h103;
    tick();
    redir_a = 1'b0;
    @(negedge clk);
    chk("a_mask_pc", pc_a, 32'h100);
    chk("a_mask_count", 32'(cnt_a), 32'd0);
    tick();
    @(negedge clk);
    chk("a_hold_pc", pc_a, 32'h100);

    // reset overrides simultaneous redirect with half-full queue
    tick();
    en_a = 1'b1;
    tick();
    en_a = 1'b0; rst_a = 1'b1; redir_a = 1'b1; tgt_a = 32'h200;
    @(negedge clk);
    chk("a_half_count", 32'(cnt_a), 32'd1);
    tick();
    rst_a = 1'b0; redir_a = 1'b0;
    @(negedge clk);
    chk("a_rst_redir_pc", pc_a, 32'h0);
    chk("a_rst_redir_count", 32'(cnt_a), 32'd0);
    chk("a_rst_redir_valid", 32'(a_if.out_valid), 32'd0);
    chk("a_final_drained", 32'(exp_a.size()), 32'd0);

    // ---- DUT B: RESET_PC=0xFFFFFFF8, wrap ----
    tick();
    @(negedge clk);
    chk("b_rst_pc", pc_b, 32'hFFFF_FFF8);
    exp_b.push_back(32'hFFFF_FFF8); exp_b.push_back(32'hFFFF_FFFC); exp_b.push_back(32'h0);
    tick();
    rst_b = 1'b0; en_b = 1'b1; b_if.out_ready = 1'b1;
    repeat (4) tick();
    b_if.out_ready = 1'b0; en_b = 1'b0;
    @(negedge clk);
    chk("b_wrap_drained", 32'(exp_b.size()), 32'd0);
    chk("b_wrap_pc", pc_b, 32'h8);

    // ---- DUT C: DEPTH=3, pointer wrap over 10 pops ----
    for (int i = 0; i < 10; i++) exp_c.push_back(32'(i * 4));
    tick();
    rst_c = 1'b0; en_c = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("c_full_count", 32'(cnt_c), 32'd3);
    chk("c_full_pc", pc_c, 32'hC);
    tick();
    for (int i = 0; i < 64 && pops_c < 10; i++) begin
      c_if.out_ready = pat[i % 16];
      tick();
    end
    c_if.out_ready = 1'b0; en_c = 1'b0;
    chk("c_pop_total", 32'(pops_c), 32'd10);
    chk("c_drained", 32'(exp_c.size()), 32'd0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
